freq_bcd_formatter: RTL
=======================

# freq_bcd_formatter

Downstream consumer of the pulse-counter stage. Takes the unsigned fixed-point frequency result (Q16.8: 16 integer bits, 8 fraction bits) when the counter flags valid data. Converts it iteratively (double-dabble) into five BCD integer digits and two BCD hundredths digits, plus a leading-zero blanking mask, for the display/UART front end. One conversion in flight, one pending request held.

## Interface
Parameters:
- INT_W, 16, integer bits of input frequency
- FRAC_W, 8, fraction bits of input frequency
- N_DIG, 5, integer BCD digits (must satisfy 10^N_DIG > 2^INT_W)

Ports:
- sys_clk  in  1  single clock for the whole block
- sys_rst  in  1  reset, synchronous, active-low
- OE  in  1  enable; low aborts and idles the block
- frequency  in  24  Q16.8 frequency from the pulse counter
- data_en  in  1  level valid flag from the pulse counter
- int_bcd  out  20  integer digits, [19:16] = ten-thousands … [3:0] = units
- frac_bcd  out  8  [7:4] = tenths, [3:0] = hundredths
- blank_mask  out  5  bit i = 1 → int digit i is a leading zero; bit 0 always 0
- bcd_valid  out  1  one-cycle pulse, outputs just updated
- busy  out  1  high in CONV and DONE

## Operation
- Request condition, sampled each cycle with OE=1: rising edge of data_en (registered previous value), OR data_en=1 and frequency ≠ last captured value.
- FSM states: IDLE, CONV, DONE.
- IDLE + request → capture frequency; frac_h = (frequency[7:0]*100) >> 8, range 0..99, truncated; clear shift registers; cnt=0; go CONV.
- CONV: each cycle, add-3 correction on every BCD nibble ≥5, then shift in one MSB. The integer engine runs 16 cycles. The fraction engine consumes the 7 bits of frac_h in cycles 0..6, then holds. After cnt==15 → DONE.
- DONE: load int_bcd, frac_bcd, blank_mask; pulse bcd_valid. If pending set → capture the pending value and go CONV. Else → IDLE.
- Request while in CONV/DONE: set pending and store that frequency. A later request overwrites the stored value (depth 1, latest wins).
- blank_mask: digit i (i = 4..1) is blanked if it and all higher digits are zero.
- OE=0: state→IDLE, pending cleared, data_en edge register cleared; outputs hold their last values; bcd_valid=0.
- Reset values: int_bcd=0, frac_bcd=0, blank_mask=5'b11110, bcd_valid=0, busy=0, state=IDLE, pending=0.
- Reset asserted mid-conversion: all state is cleared on the next clock edge; no bcd_valid is emitted for the aborted conversion.

## Timing
- Capture at edge E. Result registers and bcd_valid are visible after edge E+17: 16 CONV cycles plus 1 DONE cycle.
- busy rises after E and falls after E+17 if no request is pending.
- Back-to-back: a pending request is captured in the DONE cycle, so the next bcd_valid comes 17 cycles after the previous one.
- A request coinciding with DONE counts as pending and is captured that same cycle.
- bcd_valid is never high for two consecutive cycles.

## Structure
- Package freq_fmt_pkg: INT_W, FRAC_W, N_DIG, CONV_CYCLES=16, FRAC_MULT=100, state enum (IDLE/CONV/DONE).
- Sub-module bcd_add3: one nibble in, nibble out (+3 if ≥5). Instantiated per digit (5 integer + 2 fraction).
- Top level holds the FSM, pending buffer, edge detect, shift registers and output registers.

## Test plan
- Reset, then frequency=24'h000000 with data_en rising → after 17 cycles int_bcd=20'h00000, frac_bcd=8'h00, blank_mask=5'b11110, one bcd_valid pulse.
- frequency=24'h303980 (12345.5) → int_bcd=20'h12345, frac_bcd=8'h50, blank_mask=5'b00000.
- frequency=24'hFFFFFF → int_bcd=20'h65535, frac_bcd=8'h99; frequency=24'h000140 → int_bcd=20'h00001, frac_bcd=8'h25, blank_mask=5'b11110.
- data_en held high and frequency changed at CONV cycle 5 to 24'h006400 (100.0) → first result is delivered, then a second bcd_valid exactly 17 cycles later with int_bcd=20'h00100, blank_mask=5'b11000.
- sys_rst low at CONV cycle 8 → outputs are at reset values the next cycle, no bcd_valid; OE low mid-CONV → IDLE, outputs unchanged, no bcd_valid, pending dropped.

Source files
------------

// File: rtl/freq_bcd_formatter_pkg.sv
// Shared constants and state encoding for the frequency-to-BCD formatter.
package freq_fmt_pkg;

    localparam int INT_W       = 16;
    localparam int FRAC_W      = 8;
    localparam int N_DIG       = 5;
    localparam int CONV_CYCLES = 16;
    localparam int FRAC_MULT   = 100;

    // Hundredths value 0..99 needs 7 bits; two BCD digits hold it.
    localparam int FRAC_H_W    = 7;
    localparam int FRAC_DIG    = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/freq_bcd_formatter_add3.sv
// Double-dabble correction for one BCD nibble: add 3 when the digit is 5 or more.
module bcd_add3 (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/freq_bcd_formatter.sv
// Converts a Q16.8 frequency into five integer BCD digits, two hundredths
// digits and a leading-zero blanking mask using serial double-dabble.
//
// state | meaning
// IDLE  | waiting for a request
// CONV  | shifting one bit per cycle through the BCD engines
// DONE  | result registered out; next conversion may start here
module freq_bcd_formatter
    import freq_fmt_pkg::*;
#(
    parameter int INT_W  = freq_fmt_pkg::INT_W,
    parameter int FRAC_W = freq_fmt_pkg::FRAC_W,
    parameter int N_DIG  = freq_fmt_pkg::N_DIG
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      OE,
    input  logic [INT_W+FRAC_W-1:0]   frequency,
    input  logic                      data_en,
    output logic [4*N_DIG-1:0]        int_bcd,
    output logic [4*FRAC_DIG-1:0]     frac_bcd,
    output logic [N_DIG-1:0]          blank_mask,
    output logic                      bcd_valid,
    output logic                      busy
);

    localparam int W     = INT_W + FRAC_W;
    localparam int CNT_W = $clog2(CONV_CYCLES);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_den_prev;
    logic                    r_pend;
    logic [W-1:0]            r_pend_val;
    logic [W-1:0]            r_last;

    logic [INT_W-1:0]        r_bin;
    logic [4*N_DIG-1:0]      r_ibcd;
    logic [FRAC_H_W-1:0]     r_fsh;
    logic [4*FRAC_DIG-1:0]   r_fbcd;
    logic [CNT_W-1:0]        r_cnt;

    logic [4*N_DIG-1:0]      r_int_bcd;
    logic [4*FRAC_DIG-1:0]   r_frac_bcd;
    logic [N_DIG-1:0]        r_blank_mask;
    logic                    r_bcd_valid;

    logic                    w_req;
    logic                    w_capture;
    logic                    w_cap_from_pend;
    logic                    w_pend_set;
    logic                    w_pend_clr;
    logic                    w_load_out;
    logic [W-1:0]            w_cap_val;
    logic [FRAC_H_W-1:0]     w_frac_h;
    logic [4*N_DIG-1:0]      w_ibcd_adj;
    logic [4*FRAC_DIG-1:0]   w_fbcd_adj;
    logic [N_DIG-1:0]        w_mask;

    // A new value arrives on a rising data_en, or while data_en stays high
    // and the frequency differs from the most recently accepted value.
    assign w_req = OE & data_en & (~r_den_prev | (frequency != r_last));

    assign w_cap_val = w_cap_from_pend ? r_pend_val : frequency;

    // Truncated hundredths: (fraction * 100) >> FRAC_W.
    assign w_frac_h = FRAC_H_W'(((FRAC_W+FRAC_H_W)'(w_cap_val[FRAC_W-1:0])
                                 * (FRAC_W+FRAC_H_W)'(FRAC_MULT)) >> FRAC_W);

    for (genvar d = 0; d < N_DIG; d++) begin : g_int_add3
        bcd_add3 u_add3 (
            .i_nib (r_ibcd[4*d +: 4]),
            .o_nib (w_ibcd_adj[4*d +: 4])
        );
    end

    for (genvar d = 0; d < FRAC_DIG; d++) begin : g_frac_add3
        bcd_add3 u_add3 (
            .i_nib (r_fbcd[4*d +: 4]),
            .o_nib (w_fbcd_adj[4*d +: 4])
        );
    end

    // Leading-zero mask: a digit blanks only if it and every higher digit are zero.
    always_comb begin
        logic lz;
        w_mask = '0;
        lz     = 1'b1;
        for (int i = N_DIG - 1; i >= 1; i--) begin
            lz        = lz & (r_ibcd[4*i +: 4] == 4'd0);
            w_mask[i] = lz;
        end
    end

    // Next-state and control decode; OE low forces IDLE with no side effects.
    always_comb begin
        w_state_nxt     = r_state;
        w_capture       = 1'b0;
        w_cap_from_pend = 1'b0;
        w_pend_set      = 1'b0;
        w_pend_clr      = 1'b0;
        w_load_out      = 1'b0;
        if (!OE) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_CONV;
                    end
                end
                ST_CONV: begin
                    w_pend_set = w_req;
                    if (r_cnt == CNT_W'(CONV_CYCLES - 1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_load_out = 1'b1;
                    w_pend_clr = 1'b1;
                    if (w_req) begin
                        w_capture   = 1'b1;
                        w_state_nxt = ST_CONV;
                    end else if (r_pend) begin
                        w_capture       = 1'b1;
                        w_cap_from_pend = 1'b1;
                        w_state_nxt     = ST_CONV;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, edge detect, last-accepted value and the one-deep pending buffer.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_state    <= ST_IDLE;
            r_den_prev <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_last     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_den_prev <= OE & data_en;
            if (w_capture && !w_cap_from_pend) begin
                r_last <= frequency;
            end
            if (!OE || w_pend_clr) begin
                r_pend <= 1'b0;
            end else if (w_pend_set) begin
                r_pend     <= 1'b1;
                r_pend_val <= frequency;
                r_last     <= frequency;
            end
        end
    end

    // Shift engines: integer runs all cycles, fraction only for its 7 bits.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_bin  <= '0;
            r_ibcd <= '0;
            r_fsh  <= '0;
            r_fbcd <= '0;
            r_cnt  <= '0;
        end else if (w_capture) begin
            r_bin  <= w_cap_val[W-1:FRAC_W];
            r_ibcd <= '0;
            r_fsh  <= w_frac_h;
            r_fbcd <= '0;
            r_cnt  <= '0;
        end else if (r_state == ST_CONV && OE) begin
            {r_ibcd, r_bin} <= {w_ibcd_adj, r_bin} << 1;
            if (r_cnt < CNT_W'(FRAC_H_W)) begin
                {r_fbcd, r_fsh} <= {w_fbcd_adj, r_fsh} << 1;
            end
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Result registers update only in DONE; valid is a single-cycle strobe.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            r_int_bcd    <= '0;
            r_frac_bcd   <= '0;
            r_blank_mask <= {{(N_DIG-1){1'b1}}, 1'b0};
            r_bcd_valid  <= 1'b0;
        end else begin
            r_bcd_valid <= w_load_out;
            if (w_load_out) begin
                r_int_bcd    <= r_ibcd;
                r_frac_bcd   <= r_fbcd;
                r_blank_mask <= w_mask;
            end
        end
    end

    assign int_bcd    = r_int_bcd;
    assign frac_bcd   = r_frac_bcd;
    assign blank_mask = r_blank_mask;
    assign bcd_valid  = r_bcd_valid;
    assign busy       = (r_state != ST_IDLE);

endmodule
